// File: rtl/vga_mode_switch.sv
// VGA timing generator with a frame-synchronous display-mode switch.
// On a mode change it holds the old mode until the next frame boundary, then blanks BLANK_FRAMES frames.
module vga_mode_switch #(
  parameter int N_MODES      = 5,
  parameter int RGB_W        = 16,
  parameter int CNT_W        = 10,
  parameter int CLK_DIV      = 4,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit SYNC_POL     = 1'b0,
  parameter int BLANK_FRAMES = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_MODES-1:0]         game_mode,
  input  logic [N_MODES*RGB_W-1:0]   pix_data_in,
  output logic                       pix_en,
  output logic [CNT_W-1:0]           pix_x,
  output logic [CNT_W-1:0]           pix_y,
  output logic                       active,
  output logic                       vga_hsync,
  output logic                       vga_vsync,
  output logic [RGB_W-1:0]           rgb,
  output logic [N_MODES-1:0]         cur_mode,
  output logic                       switching
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BC_W  = (BLANK_FRAMES > 0) ? $clog2(BLANK_FRAMES + 1) : 1;

  typedef enum logic [1:0] {RUN, PEND, BLANK} state_t;

  state_t               state_q;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [CNT_W-1:0]     h_q, h_d, v_q, v_d;
  logic [N_MODES-1:0]   cur_mode_q, pend_q, pend_nx, req;
  logic [BC_W-1:0]      blank_cnt_q;
  logic [RGB_W-1:0]     rgb_q, sel;
  logic                 active_q, hsync_q, vsync_q;
  logic                 h_last, v_last, fb, in_act, hs_on, vs_on;

  always_comb begin
    div_d  = (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
    h_last = (h_q == CNT_W'(H_TOT - 1));
    v_last = (v_q == CNT_W'(V_TOT - 1));
    h_d    = h_q;
    v_d    = v_q;
    if (pix_en) begin
      h_d = h_last ? '0 : h_q + CNT_W'(1);
      if (h_last) v_d = v_last ? '0 : v_q + CNT_W'(1);
    end
    fb      = pix_en & h_last & v_last;
    // Two's-complement trick isolates the lowest set request bit.
    req     = game_mode & (~game_mode + N_MODES'(1));
    pend_nx = (req != '0) ? req : pend_q;
    in_act  = (h_q < CNT_W'(H_ACTIVE)) && (v_q < CNT_W'(V_ACTIVE));
    hs_on   = (h_q >= CNT_W'(H_ACTIVE + H_FP)) && (h_q <= CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1));
    vs_on   = (v_q >= CNT_W'(V_ACTIVE + V_FP)) && (v_q <= CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1));
    sel     = '0;
    for (int k = 0; k < N_MODES; k++) begin
      if (cur_mode_q[k]) sel = sel | pix_data_in[k*RGB_W +: RGB_W];
    end
  end

  // Gated by rst so the tick is low for the whole reset, even with CLK_DIV=1.
  assign pix_en = rst & (div_q == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      h_q      <= '0;
      v_q      <= '0;
      rgb_q    <= '0;
      active_q <= 1'b0;
      hsync_q  <= ~SYNC_POL;
      vsync_q  <= ~SYNC_POL;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      if (pix_en) begin
        active_q <= in_act;
        hsync_q  <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync_q  <= vs_on ? SYNC_POL : ~SYNC_POL;
        rgb_q    <= (in_act && state_q != BLANK) ? sel : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= RUN;
      cur_mode_q  <= '0;
      pend_q      <= '0;
      blank_cnt_q <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (req != '0 && req != cur_mode_q) begin
            pend_q  <= req;
            state_q <= PEND;
          end
        end
        PEND: begin
          if (req != '0 && req == cur_mode_q) begin
            state_q <= RUN;
          end else begin
            pend_q <= pend_nx;
            if (fb) begin
              if (BLANK_FRAMES == 0) begin
                cur_mode_q <= pend_nx;
                state_q    <= RUN;
              end else begin
                blank_cnt_q <= BC_W'(BLANK_FRAMES);
                state_q     <= BLANK;
              end
            end
          end
        end
        BLANK: begin
          pend_q <= pend_nx;
          if (fb) begin
            if (blank_cnt_q == BC_W'(1)) begin
              cur_mode_q <= pend_nx;
              state_q    <= RUN;
            end else begin
              blank_cnt_q <= blank_cnt_q - BC_W'(1);
            end
          end
        end
        default: state_q <= RUN;
      endcase
    end
  end

  assign pix_x     = h_q;
  assign pix_y     = v_q;
  assign active    = active_q;
  assign vga_hsync = hsync_q;
  assign vga_vsync = vsync_q;
  assign rgb       = rgb_q;
  assign cur_mode  = cur_mode_q;
  assign switching = (state_q != RUN);

endmodule

// File: tb/tb_vga_mode_switch.sv
// Randomized bench for vga_mode_switch on a shrunken raster, checked every clock against a frame-arithmetic model.
module tb_vga_mode_switch;

  localparam int NM = 5, RW = 16, CW = 10, D = 3;
  localparam int HA = 8, HF = 2, HS = 3, HB = 2, VA = 6, VF = 1, VS = 2, VB = 1;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, FRAME = HT * VT;
  localparam bit POL = 1'b0;
  localparam int BF = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NM-1:0]     game_mode;
  logic [NM*RW-1:0]  pix_data_in;
  logic              pix_en, active, vga_hsync, vga_vsync, switching;
  logic [CW-1:0]     pix_x, pix_y;
  logic [RW-1:0]     rgb;
  logic [NM-1:0]     cur_mode;

  int n_checks = 0;
  int n_fail   = 0;

  vga_mode_switch #(
    .N_MODES(NM), .RGB_W(RW), .CNT_W(CW), .CLK_DIV(D),
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(POL), .BLANK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .game_mode(game_mode), .pix_data_in(pix_data_in),
    .pix_en(pix_en), .pix_x(pix_x), .pix_y(pix_y), .active(active),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .rgb(rgb),
    .cur_mode(cur_mode), .switching(switching)
  );

  always #5 clk = ~clk;

  // Reference model: clock edges since reset, frame positions by division.
  int            e;
  logic [NM-1:0] m_cur, m_pend;
  int            m_blank;
  logic [RW-1:0] x_rgb;
  logic          x_act, x_hs, x_vs;

  function automatic logic [NM-1:0] lowbit(input logic [NM-1:0] g);
    for (int i = 0; i < NM; i++) if (g[i]) return NM'(1) << i;
    return '0;
  endfunction

  function automatic logic [RW-1:0] chan(input logic [NM-1:0] m, input logic [NM*RW-1:0] d);
    for (int i = 0; i < NM; i++) if (m[i]) return d[i*RW +: RW];
    return '0;
  endfunction

  always @(posedge clk or negedge rst) begin : model
    int pos, h, v;
    bit pe, fb;
    logic [NM-1:0] rq;
    if (!rst) begin
      e = 0; m_cur = '0; m_pend = '0; m_blank = 0;
      x_rgb = '0; x_act = 1'b0; x_hs = ~POL; x_vs = ~POL;
    end else begin
      pe  = (e % D) == D - 1;
      pos = (e / D) % FRAME;
      h   = pos % HT;
      v   = pos / HT;
      fb  = pe && (pos == FRAME - 1);
      if (pe) begin
        x_act = (h < HA) && (v < VA);
        x_hs  = (h >= HA + HF && h < HA + HF + HS) ? POL : ~POL;
        x_vs  = (v >= VA + VF && v < VA + VF + VS) ? POL : ~POL;
        x_rgb = (x_act && m_blank == 0) ? chan(m_cur, pix_data_in) : '0;
      end
      rq = lowbit(game_mode);
      if (m_blank > 0) begin
        if (rq != 0) m_pend = rq;
        if (fb) begin
          if (m_blank == 1) begin m_cur = m_pend; m_pend = '0; m_blank = 0; end
          else m_blank = m_blank - 1;
        end
      end else if (m_pend != 0) begin
        if (rq != 0 && rq == m_cur) m_pend = '0;
        else begin
          if (rq != 0) m_pend = rq;
          if (fb) begin
            if (BF == 0) begin m_cur = m_pend; m_pend = '0; end
            else m_blank = BF;
          end
        end
      end else if (rq != 0 && rq != m_cur) begin
        m_pend = rq;
      end
      e = e + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    int pos;
    pos = (e / D) % FRAME;
    check("pix_en",    32'(pix_en),    32'(rst && ((e % D) == D - 1)));
    check("pix_x",     32'(pix_x),     32'(pos % HT));
    check("pix_y",     32'(pix_y),     32'(pos / HT));
    check("rgb",       32'(rgb),       32'(x_rgb));
    check("active",    32'(active),    32'(x_act));
    check("hsync",     32'(vga_hsync), 32'(x_hs));
    check("vsync",     32'(vga_vsync), 32'(x_vs));
    check("cur_mode",  32'(cur_mode),  32'(m_cur));
    check("switching", 32'(switching), 32'((m_pend != 0) || (m_blank != 0)));
  endtask

  always @(negedge clk) check_all();

  task automatic run(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
      for (int k = 0; k < NM; k++) pix_data_in[k*RW +: RW] = 16'($urandom);
      pix_data_in[2*RW +: RW] = 16'hF800;
    end
  endtask

  initial begin
    int w;
    rst = 1'b0;
    game_mode = '0;
    pix_data_in = '0;
    run(3);
    rst = 1'b1;
    run(2 * FRAME * D);
    game_mode = 5'b00100;
    run(4 * FRAME * D);
    game_mode = 5'b10010;
    run(4 * FRAME * D);
    game_mode = 5'b01000;
    run(20);
    game_mode = 5'b00001;
    run(4 * FRAME * D);
    game_mode = 5'b00010;
    run(10);
    game_mode = 5'b00001;
    run(2 * FRAME * D);
    game_mode = '0;
    run(2 * FRAME * D);
    for (int s = 0; s < 30; s++) begin
      game_mode = ($urandom_range(0, 3) == 0) ? '0 : NM'($urandom_range(1, 31));
      run($urandom_range(5, 700));
    end
    game_mode = (m_cur == 5'b00001) ? 5'b00010 : 5'b00001;
    w = 0;
    while (!(m_blank > 0 && ((e / D) % FRAME) > 40 && ((e / D) % FRAME) < 100) && w < 5000) begin
      run(1);
      w++;
    end
    check("blank_reached", 32'(w < 5000), 32'd1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check_all();
    run(4);
    rst = 1'b1;
    game_mode = 5'b00100;
    run(2 * FRAME * D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
